// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the 1 KB data memory: one access at a time, one-cycle strobes, done pulse to owner.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port 1 has fixed priority.
module mem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wd,
  output logic [31:0] p0_rd,
  output logic        p0_done,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
  output logic [31:0] p1_rd,
  output logic        p1_done,
  output logic        p1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // state  | meaning
  // IDLE   | arbitrate and latch the winning request
  // ACCESS | one-cycle memory strobe (suppressed when out of range)
  // RESP   | capture mem_rd into owner's read register
  // DONE   | completion pulse (+err) to owner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t      state, state_nxt;
  logic        owner;
  logic        lat_we;
  logic        oor;
  logic        grant_any;
  logic        grant_sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wd;

`ifdef MEM_ARB_RR_EN
  logic        last_grant;
`endif

  always_comb begin
    grant_any = p0_req | p1_req;
`ifdef MEM_ARB_RR_EN
    if (p0_req && p1_req) grant_sel = ~last_grant;
    else                  grant_sel = p1_req;
`else
    grant_sel = p1_req;
`endif
    sel_we   = grant_sel ? p1_we   : p0_we;
    sel_addr = grant_sel ? p1_addr : p0_addr;
    sel_wd   = grant_sel ? p1_wd   : p0_wd;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    p0_done   = 1'b0;
    p1_done   = 1'b0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    case (state)
      IDLE:   if (grant_any) state_nxt = ACCESS;
      ACCESS: begin
        // rst gating keeps a reset cycle from ever issuing a memory command
        if (!oor) begin
          mem_read  = !lat_we && !rst;
          mem_write = lat_we && !rst;
        end
        state_nxt = (!oor && !lat_we) ? RESP : DONE;
      end
      RESP:   state_nxt = DONE;
      DONE: begin
        p0_done   = !owner && !rst;
        p1_done   = owner && !rst;
        p0_err    = !owner && !rst && oor;
        p1_err    = owner && !rst && oor;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      lat_we   <= 1'b0;
      oor      <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      p0_rd    <= '0;
      p1_rd    <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        owner    <= grant_sel;
        lat_we   <= sel_we;
        mem_addr <= sel_addr;
        mem_wd   <= sel_wd;
        oor      <= (sel_addr > MAX_ADDR);
`ifdef MEM_ARB_RR_EN
        last_grant <= grant_sel;
`endif
      end
      if (state == RESP) begin
        if (owner) p1_rd <= mem_rd;
        else       p0_rd <= mem_rd;
      end
      // rejected read returns zero, visible in the DONE cycle
      if (state == ACCESS && oor && !lat_we) begin
        if (owner) p1_rd <= '0;
        else       p0_rd <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small registered-read memory model.
// Expected grant order follows MEM_ARB_RR_EN when defined, fixed port-1 priority otherwise.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;
  logic [31:0] p0_rd, p1_rd;
  logic        p0_done, p0_err, p1_done, p1_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  int g_n  = 0;
  int g_base, s_base;
  logic [31:0] grant_log [0:63];
  logic        mem_init;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd),
    .p0_rd(p0_rd), .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd),
    .p1_rd(p1_rd), .p1_done(p1_done), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // memory model: word i initialised to 0x1000_0000 + i
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem_rd <= '0;
    end else begin
      if (mem_write) mem[mem_addr[9:2]] <= mem_wd;
      if (mem_read)  mem_rd <= mem[mem_addr[9:2]];
    end
  end

  always @(negedge clk) begin
    if (mem_read)  n_rd <= n_rd + 1;
    if (mem_write) n_wr <= n_wr + 1;
    if (p0_done || p1_done) begin
      grant_log[g_n[5:0]] <= p1_done ? 32'd1 : 32'd0;
      g_n <= g_n + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wd = '0; p1_wd = '0;
    mem_init = 1'b1;
    do_reset();
    mem_init = 1'b0;

    // reset state
    chk("rst_done_err", 32'({p0_done, p1_done, p0_err, p1_err}), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_p0_rd", p0_rd, 32'd0);
    chk("rst_p1_rd", p1_rd, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);

    // p1 write 0xDEADBEEF to 16
    s_base = n_wr;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd16; p1_wd = 32'hDEAD_BEEF;
    step();
    chk("wr_strobe", 32'({mem_write, mem_read}), 32'd2);
    chk("wr_addr", mem_addr, 32'd16);
    chk("wr_wd", mem_wd, 32'hDEAD_BEEF);
    step();
    chk("wr_done", 32'({p1_done, p1_err, p0_done}), 32'd4);
    chk("wr_strobe_off", 32'(mem_write), 32'd0);
    p1_req = 1'b0;
    step();
    chk("wr_one_strobe", 32'(n_wr - s_base), 32'd1);
    chk("wr_done_pulse", 32'(p1_done), 32'd0);

    // p1 read back 16
    p1_req = 1'b1; p1_we = 1'b0;
    step();
    chk("rd_strobe", 32'({mem_read, mem_write}), 32'd2);
    step();
    chk("rd_resp_quiet", 32'({mem_read, p1_done}), 32'd0);
    step();
    chk("rd_done", 32'({p1_done, p1_err}), 32'd2);
    chk("rd_data", p1_rd, 32'hDEAD_BEEF);
    chk("rd_p0_untouched", p0_rd, 32'd0);
    p1_req = 1'b0;
    step();

    // simultaneous reads from reset
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd4;
    step(); step(); step();
    chk("sim_first", 32'({p0_done, p1_done}), (RR != 0) ? 32'd2 : 32'd1);
    chk("sim_first_rd", (RR != 0) ? p0_rd : p1_rd, (RR != 0) ? 32'h1000_0000 : 32'h1000_0001);
    if (RR != 0) p0_req = 1'b0; else p1_req = 1'b0;
    step(); step(); step();
    chk("sim_second_early", 32'({p0_done, p1_done}), 32'd0);
    step();
    chk("sim_second", 32'({p0_done, p1_done}), (RR != 0) ? 32'd1 : 32'd2);
    chk("sim_second_rd", (RR != 0) ? p1_rd : p0_rd, (RR != 0) ? 32'h1000_0001 : 32'h1000_0000);
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    // constant contention for 8 accesses
    do_reset();
    g_base = g_n;
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (32) step();
    p0_req = 1'b0; p1_req = 1'b0;
    step(); step();
    chk("fair_count", 32'(g_n - g_base), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fair_grant%0d", i), grant_log[g_base + i],
          (RR != 0) ? 32'(i % 2) : 32'd1);

    // out-of-range read on p0, then highest legal write on p1
    s_base = n_rd + n_wr;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd1021;
    step();
    chk("oor_no_strobe", 32'({mem_read, mem_write}), 32'd0);
    step();
    chk("oor_done_err", 32'({p0_done, p0_err}), 32'd3);
    chk("oor_rd_zero", p0_rd, 32'd0);
    p0_req = 1'b0;
    step();
    chk("oor_strobe_cnt", 32'(n_rd + n_wr - s_base), 32'd0);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd1020; p1_wd = 32'hCAFE_F00D;
    step();
    chk("top_wr_strobe", 32'(mem_write), 32'd1);
    chk("top_wr_addr", mem_addr, 32'd1020);
    step();
    chk("top_wr_done", 32'({p1_done, p1_err}), 32'd2);
    p1_req = 1'b0;
    step();

    // reset during ACCESS of a write to 8
    s_base = n_wr;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd8; p1_wd = 32'h5555_5555;
    step();
    rst = 1'b1;
    p1_req = 1'b0;
    #1;
    chk("rst_mid_no_write", 32'(mem_write), 32'd0);
    step();
    rst = 1'b0;
    g_base = g_n;
    repeat (4) step();
    chk("rst_mid_no_done", 32'(g_n - g_base), 32'd0);
    chk("rst_mid_wr_cnt", 32'(n_wr - s_base), 32'd0);
    p1_req = 1'b1; p1_we = 1'b0;
    step(); step(); step();
    chk("rst_mid_readback_done", 32'(p1_done), 32'd1);
    chk("rst_mid_readback", p1_rd, 32'h1000_0002);
    p1_req = 1'b0;
    step();

    // p0 arrives while p1 read is in RESP
    s_base = n_rd;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd12;
    step(); step();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd1020;
    step();
    chk("busy_p1_done", 32'({p1_done, p0_done}), 32'd2);
    chk("busy_p1_rd", p1_rd, 32'h1000_0003);
    p1_req = 1'b0;
    step();
    chk("busy_idle_quiet", 32'(mem_read), 32'd0);
    step();
    chk("busy_p0_strobe", 32'(mem_read), 32'd1);
    chk("busy_p0_addr", mem_addr, 32'd1020);
    step(); step();
    chk("busy_p0_done", 32'({p0_done, p0_err}), 32'd2);
    chk("busy_p0_rd", p0_rd, 32'hCAFE_F00D);
    p0_req = 1'b0;
    step();
    chk("busy_rd_cnt", 32'(n_rd - s_base), 32'd2);
    chk("busy_p1_rd_held", p1_rd, 32'h1000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the 1 KB byte-addressed data memory (32-bit word access, one-cycle registered read). Port 0 serves instruction fetch and port 1 serves load/store. The block picks one request at a time, drives the memory's read/write strobes for exactly one cycle, captures read data on the following cycle, and returns a one-cycle completion pulse to the owning port. Out-of-range word addresses are rejected without touching memory.

## Interface
- MEM_BYTES, 1024: memory size in bytes. Legal word address range is 0..MEM_BYTES-4.
- clk  in  1: single clock; all state updates on posedge.
- rst  in  1: synchronous, active-high reset.
- p0_req, p1_req  in  1: request valid. Held from assertion through the cycle its pN_done is high.
- p0_we, p1_we  in  1: 1 = write, 0 = read. Stable while req is high.
- p0_addr, p1_addr  in  32: byte address. Stable while req is high.
- p0_wd, p1_wd  in  32: write data. Stable while req is high.
- p0_rd, p1_rd  out  32: read data. Registered. Valid in the done cycle and held until that port's next done.
- p0_done, p1_done  out  1: one-cycle completion pulse.
- p0_err, p1_err  out  1: high with done when the address was out of range.
- mem_read, mem_write  out  1: memory strobes. At most one is high, for one cycle per access.
- mem_addr, mem_wd  out  32: latched address and write data of the current access.
- mem_rd  in  32: memory read data, valid the cycle after mem_read.

## Operation
- FSM states: IDLE, ACCESS, RESP, DONE.
- IDLE:
  - If any req is high, select a winner (see Configuration).
  - Latch owner, we, addr and wd; compute oor = (addr > MEM_BYTES-4).
  - Go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - If !oor: mem_read = !we, mem_write = we. mem_addr and mem_wd present the latched values.
  - If oor: no strobe.
  - Next state: RESP for an in-range read, otherwise DONE.
- RESP: register mem_rd into the owner's pN_rd. Go to DONE.
- DONE:
  - Owner's pN_done = 1; pN_err = oor.
  - On an oor read, the owner's pN_rd is loaded with 0.
  - Go to IDLE.
- The non-owning port's outputs do not change during another port's access.
- Arbitration only happens in IDLE. A request arriving mid-access waits and is never dropped.
- A requester may present a new request in the cycle after done. Back-to-back requests from the same port are allowed.
- Reset values:
  - State = IDLE.
  - All done, err, mem_read and mem_write = 0.
  - pN_rd, mem_addr, mem_wd = 0.
  - Round-robin last-grant = port 1, so port 0 wins the first tie.
- Reset mid-operation:
  - mem_read and mem_write are gated by !rst, so no memory command is issued in a cycle where rst is high.
  - The in-flight access is abandoned with no done pulse.
  - The requester must re-issue after reset.

## Timing
- Request sampled in IDLE at cycle 0.
- Read: strobe in cycle 1, capture in cycle 2, done in cycle 3. Four cycles per read including IDLE.
- Write: strobe in cycle 1 (memory updated at the end of cycle 1), done in cycle 2. Three cycles per write.
- Out-of-range access of either kind: done+err in cycle 2.
- Simultaneous requests are resolved in the same IDLE cycle. The loser is sampled in the IDLE after the winner's DONE.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin. On a tie, grant the port not granted most recently.
  - The last-grant register updates on every grant.
- MEM_ARB_RR_EN undefined:
  - Fixed priority: port 1 (data) always beats port 0.
  - No last-grant register.

## Test plan
- Single write then read:
  - p1 writes 0xDEADBEEF to addr 16 → mem_write high for exactly one cycle with mem_addr = 16; p1_done at cycle 2.
  - p1 then reads addr 16 → mem_read in cycle 1; p1_rd = 0xDEADBEEF with p1_done at cycle 3; p1_err = 0.
- Simultaneous reads:
  - p0 and p1 both request reads (addr 0 and addr 4) from reset.
  - With RR_EN: p0 done first, p1 done 4 cycles later.
  - Without RR_EN: p1 first.
- Fairness under constant contention:
  - Both ports keep req high for 8 accesses.
  - With RR_EN: grants alternate p0, p1, p0, …
  - Without RR_EN: p0 is starved; all 8 grants go to p1.
- Out-of-range:
  - p0 reads addr 1021 → no strobe; p0_done and p0_err at cycle 2; p0_rd = 0.
  - p1 writes addr 1020 → accepted, err = 0.
- Reset mid-write:
  - p1 write to addr 8 with rst asserted in the ACCESS cycle → mem_write stays 0, no p1_done.
  - A later read of addr 8 returns the prior contents.
- Request during busy:
  - p0 asserts req while a p1 read is in RESP → p0 is sampled in the IDLE following p1's DONE.
  - p0 completes correctly with no lost or duplicated strobe.
